trap_wave_sched: RTL and testbench

Frame-tick scheduler that launches a wave of up to NUM_TRAPS flying traps in a fixed order once the player enters a trigger zone on one map. It tracks each trap's flight lifetime and aborts or re-arms the wave on hit, map change, restart or reset. It sits between the player/map state and the trap position/draw logic. It supplies per-trap launch pulses and active flags; trap motion and pixel arbitration live downstream.

---
 rtl/trap_pkg.sv | 21 ++
 rtl/trap_flight_timer.sv | 66 ++++++
 rtl/trap_wave_sched.sv | 185 ++++++++++++++++++
 tb/tb_trap_wave_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_pkg
// Brief    : Shared types and constants for the trap wave scheduler.
// Revision : 1.0
// ============================================================================
package trap_pkg;

    localparam int FRAME_CNT_W  = 6;
    localparam int MAN_FOOT_OFS = 20;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_GAP      = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } wave_state_t;

endpackage
`default_nettype wire

// File: rtl/trap_flight_timer.sv
`default_nettype none
// ============================================================================
// Module   : trap_flight_timer
// Brief    : Per-trap flight lifetime counter, FLIGHT_FRAMES ticks per launch.
// Revision : 1.0
// ============================================================================
module trap_flight_timer
    import trap_pkg::*;
#(
    parameter int FLIGHT_FRAMES = 63
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic start,
    input  logic tick,
    output logic active,
    output logic done
);

    localparam logic [FRAME_CNT_W-1:0] c_CNT_LAST = FRAME_CNT_W'(FLIGHT_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] c_CNT_ONE  = FRAME_CNT_W'(1);

    logic [FRAME_CNT_W-1:0] cnt_q;
    logic [FRAME_CNT_W-1:0] cnt_d;
    logic                   active_q;
    logic                   active_d;
    logic                   done_d;

    // The launch edge itself is not counted; expiry lands on the FLIGHT_FRAMES-th later tick.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (clr) begin
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q && tick) begin
            if (cnt_q == c_CNT_LAST) begin
                cnt_d    = '0;
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign done   = done_d;

endmodule
`default_nettype wire

// File: rtl/trap_wave_sched.sv
`default_nettype none
// ============================================================================
// Module   : trap_wave_sched
// Brief    : Frame-tick scheduler launching a fixed-order wave of flying traps.
// Revision : 1.0
// ============================================================================
module trap_wave_sched
    import trap_pkg::*;
#(
    parameter int         NUM_TRAPS     = 4,
    parameter int         GAP_FRAMES    = 8,
    parameter int         FLIGHT_FRAMES = 63,
    parameter logic [1:0] MAP_ID        = 2'b01,
    parameter int         TRIG_X_L      = 352,
    parameter int         TRIG_X_R      = 384,
    parameter int         TRIG_Y_U      = 192,
    parameter int         TRIG_Y_D      = 288
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 restart,
    input  logic                 frame_clk,
    input  logic [1:0]           inmap,
    input  logic [9:0]           man_x,
    input  logic [9:0]           man_y,
    input  logic                 hit,
    output logic [NUM_TRAPS-1:0] launch,
    output logic [NUM_TRAPS-1:0] active,
    output logic                 busy,
    output logic                 wave_done
);

    localparam int                     IDX_W      = 4;
    localparam logic [IDX_W-1:0]       c_LAST_IDX = IDX_W'(NUM_TRAPS - 1);
    localparam logic [IDX_W-1:0]       c_IDX_ONE  = IDX_W'(1);
    localparam logic [FRAME_CNT_W-1:0] c_GAP_LAST = FRAME_CNT_W'(GAP_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] c_GAP_ONE  = FRAME_CNT_W'(1);
    localparam logic [NUM_TRAPS-1:0]   c_ONE_HOT0 = NUM_TRAPS'(1);
    localparam logic [9:0]             c_X_L      = 10'(TRIG_X_L);
    localparam logic [9:0]             c_X_R      = 10'(TRIG_X_R);
    localparam logic [10:0]            c_Y_U      = 11'(TRIG_Y_U);
    localparam logic [10:0]            c_Y_D      = 11'(TRIG_Y_D);
    localparam logic [10:0]            c_FOOT     = 11'(MAN_FOOT_OFS);

    wave_state_t            state_q;
    wave_state_t            state_d;
    logic                   fc_q;
    logic                   fc_d;
    logic                   tick_q;
    logic                   tick_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [FRAME_CNT_W-1:0] gap_cnt_q;
    logic [FRAME_CNT_W-1:0] gap_cnt_d;
    logic [NUM_TRAPS-1:0]   launch_q;
    logic [NUM_TRAPS-1:0]   launch_d;
    logic                   wave_done_q;
    logic                   wave_done_d;
    logic                   timer_clr;
    logic [NUM_TRAPS-1:0]   timer_active;
    logic [NUM_TRAPS-1:0]   timer_done;
    logic [10:0]            foot_y;
    logic                   trig;
    logic                   on_map;
    logic                   unused_done;

    // Widened by one bit so a player near the bottom edge cannot wrap into the box.
    assign foot_y = {1'b0, man_y} + c_FOOT;
    assign trig   = (man_x >= c_X_L) && (man_x <= c_X_R) &&
                    (foot_y >= c_Y_U) && (foot_y <= c_Y_D);
    assign on_map = (inmap == MAP_ID);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        launch_d    = '0;
        wave_done_d = 1'b0;
        timer_clr   = 1'b0;
        fc_d        = frame_clk;
        tick_d      = frame_clk & ~fc_q;

        if (restart) begin
            state_d   = ST_DISARMED;
            idx_d     = '0;
            gap_cnt_d = '0;
            timer_clr = 1'b1;
            fc_d      = 1'b0;
            tick_d    = 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (on_map) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED, ST_GAP, ST_DRAIN: begin
                    if (!on_map) begin
                        state_d   = ST_DISARMED;
                        idx_d     = '0;
                        gap_cnt_d = '0;
                        timer_clr = 1'b1;
                    end else if (hit) begin
                        state_d     = ST_DONE;
                        idx_d       = '0;
                        gap_cnt_d   = '0;
                        timer_clr   = 1'b1;
                        wave_done_d = 1'b1;
                    end else if (state_q == ST_ARMED) begin
                        if (tick_q && trig) begin
                            launch_d  = c_ONE_HOT0;
                            idx_d     = c_IDX_ONE;
                            gap_cnt_d = '0;
                            state_d   = (NUM_TRAPS == 1) ? ST_DRAIN : ST_GAP;
                        end
                    end else if (state_q == ST_GAP) begin
                        if (tick_q) begin
                            if (gap_cnt_q == c_GAP_LAST) begin
                                launch_d  = c_ONE_HOT0 << idx_q;
                                gap_cnt_d = '0;
                                idx_d     = idx_q + c_IDX_ONE;
                                if (idx_q == c_LAST_IDX) begin
                                    state_d = ST_DRAIN;
                                end
                            end else begin
                                gap_cnt_d = gap_cnt_q + c_GAP_ONE;
                            end
                        end
                    end else if (timer_active == '0) begin
                        state_d     = ST_DONE;
                        wave_done_d = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_DISARMED;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_DISARMED;
            fc_q        <= 1'b0;
            tick_q      <= 1'b0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            launch_q    <= '0;
            wave_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            launch_q    <= launch_d;
            wave_done_q <= wave_done_d;
        end
    end

    for (genvar gi = 0; gi < NUM_TRAPS; gi++) begin : g_trap
        trap_flight_timer #(
            .FLIGHT_FRAMES(FLIGHT_FRAMES)
        ) u_timer (
            .Clk    (Clk),
            .Reset  (Reset),
            .clr    (timer_clr),
            .start  (launch_d[gi]),
            .tick   (tick_q),
            .active (timer_active[gi]),
            .done   (timer_done[gi])
        );
    end

    assign unused_done = ^timer_done;

    assign launch    = launch_q;
    assign active    = timer_active;
    assign busy      = (state_q == ST_GAP) || (state_q == ST_DRAIN);
    assign wave_done = wave_done_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_wave_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_wave_sched
// Brief    : Scoreboard bench for trap_wave_sched against a tick-count model.
// Revision : 1.0
// ============================================================================
module tb_trap_wave_sched;

    localparam int         NUM    = 3;
    localparam int         GAP    = 4;
    localparam int         FLIGHT = 10;
    localparam logic [1:0] MAP    = 2'b01;

    localparam int M_OFF   = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic [NUM-1:0] launch;
        logic [NUM-1:0] active;
        logic           busy;
        logic           wave_done;
    } obs_t;

    logic           Clk       = 1'b0;
    logic           Reset     = 1'b1;
    logic           restart   = 1'b0;
    logic           frame_clk = 1'b0;
    logic [1:0]     inmap     = 2'b00;
    logic [9:0]     man_x     = '0;
    logic [9:0]     man_y     = '0;
    logic           hit       = 1'b0;
    logic [NUM-1:0] launch;
    logic [NUM-1:0] active;
    logic           busy;
    logic           wave_done;

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    int             m_mode = M_OFF;
    int             m_k    = 0;
    bit             m_fc   = 1'b0;
    bit             m_tick = 1'b0;
    logic [NUM-1:0] m_act  = '0;

    trap_wave_sched #(
        .NUM_TRAPS     (NUM),
        .GAP_FRAMES    (GAP),
        .FLIGHT_FRAMES (FLIGHT),
        .MAP_ID        (MAP)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .restart   (restart),
        .frame_clk (frame_clk),
        .inmap     (inmap),
        .man_x     (man_x),
        .man_y     (man_y),
        .hit       (hit),
        .launch    (launch),
        .active    (active),
        .busy      (busy),
        .wave_done (wave_done)
    );

    always #5 Clk = ~Clk;

    function automatic bit in_box(input logic [9:0] x, input logic [9:0] y);
        int fy;
        fy = int'(y) + 20;
        return (int'(x) >= 352) && (int'(x) <= 384) && (fy >= 192) && (fy <= 288);
    endfunction

    // Wave progress is tracked as ticks elapsed since the trigger tick (m_k):
    // trap i launches at k == i*GAP and lands at k == i*GAP + FLIGHT.
    task automatic model_step(output obs_t e);
        logic [NUM-1:0] l;
        bit             wd;
        bit             tk;
        l  = '0;
        wd = 1'b0;
        tk = m_tick;
        if (restart) begin
            m_mode = M_OFF;
            m_k    = 0;
            m_act  = '0;
            m_fc   = 1'b0;
            m_tick = 1'b0;
        end else begin
            if (m_mode == M_OFF) begin
                if (inmap == MAP) m_mode = M_ARMED;
            end else if (m_mode == M_ARMED || m_mode == M_RUN) begin
                if (inmap != MAP) begin
                    m_mode = M_OFF;
                    m_act  = '0;
                    m_k    = 0;
                end else if (hit) begin
                    m_mode = M_DONE;
                    m_act  = '0;
                    wd     = 1'b1;
                end else if (m_mode == M_ARMED) begin
                    if (tk && in_box(man_x, man_y)) begin
                        m_mode   = M_RUN;
                        m_k      = 0;
                        l[0]     = 1'b1;
                        m_act[0] = 1'b1;
                    end
                end else if (m_k >= (NUM - 1) * GAP && m_act == '0) begin
                    m_mode = M_DONE;
                    wd     = 1'b1;
                end else if (tk) begin
                    m_k++;
                    for (int i = 0; i < NUM; i++) begin
                        if (m_k == i * GAP) begin
                            l[i]     = 1'b1;
                            m_act[i] = 1'b1;
                        end else if (m_k == i * GAP + FLIGHT) begin
                            m_act[i] = 1'b0;
                        end
                    end
                end
            end
            m_tick = frame_clk && !m_fc;
            m_fc   = frame_clk;
        end
        e.launch    = l;
        e.active    = m_act;
        e.busy      = (m_mode == M_RUN);
        e.wave_done = wd;
    endtask

    initial begin : model
        obs_t e;
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                m_mode = M_OFF;
                m_k    = 0;
                m_fc   = 1'b0;
                m_tick = 1'b0;
                m_act  = '0;
                e      = '0;
                sb_q.delete();
                sb_q.push_back(e);
            end else begin
                model_step(e);
                sb_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        obs_t exp_o;
        obs_t got;
        forever begin
            @(negedge Clk);
            if (sb_q.size() != 0) begin
                exp_o = sb_q.pop_front();
                got   = {launch, active, busy, wave_done};
                checks++;
                if (got !== exp_o) begin
                    errors++;
                    $display("FAIL outputs @%0t: actual launch=%b active=%b busy=%b done=%b, required launch=%b active=%b busy=%b done=%b",
                             $time, got.launch, got.active, got.busy, got.wave_done,
                             exp_o.launch, exp_o.active, exp_o.busy, exp_o.wave_done);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        cyc(int'($urandom_range(1, 3)));
        frame_clk = 1'b0;
        cyc(int'($urandom_range(1, 3)));
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic place_in_box();
        man_x = 10'(352 + $urandom_range(0, 32));
        man_y = 10'(172 + $urandom_range(0, 96));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        cyc(1);
    endtask

    initial begin : stimulus
        cyc(3);
        Reset = 1'b0;
        cyc(2);

        // Right position, wrong map: nothing may launch until the map matches.
        place_in_box();
        inmap = 2'b00;
        ticks(20);
        inmap = MAP;
        cyc(1);
        ticks(24);
        cyc(3);

        // Hit after the second launch aborts the wave.
        do_restart();
        inmap = MAP;
        place_in_box();
        cyc(1);
        ticks(6);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        ticks(5);

        // Map change mid-wave, then a full relaunch.
        do_restart();
        inmap = MAP;
        place_in_box();
        cyc(1);
        ticks(5);
        inmap = 2'b10;
        ticks(2);
        inmap = MAP;
        place_in_box();
        ticks(24);

        // Frame clock held high yields a single tick.
        do_restart();
        inmap = MAP;
        place_in_box();
        cyc(1);
        frame_clk = 1'b1;
        cyc(50);
        frame_clk = 1'b0;
        cyc(2);
        ticks(3);

        // Bottom-edge and box-border positions.
        do_restart();
        inmap = MAP;
        man_x = 10'd360;
        man_y = 10'd1020;
        ticks(4);
        man_y = 10'd1023;
        ticks(2);
        man_x = 10'd351; man_y = 10'd200; ticks(2);
        man_x = 10'd385; ticks(2);
        man_x = 10'd370; man_y = 10'd171; ticks(2);
        man_y = 10'd269; ticks(2);
        man_x = 10'd384; man_y = 10'd268; ticks(24);

        // Asynchronous reset mid-GAP clears outputs before the next clock edge.
        do_restart();
        inmap = MAP;
        place_in_box();
        cyc(1);
        ticks(2);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({launch, active, busy, wave_done} !== '0) begin
            errors++;
            $display("FAIL async_reset: actual launch=%b active=%b busy=%b done=%b, required all zero",
                     launch, active, busy, wave_done);
        end
        cyc(2);
        Reset = 1'b0;
        ticks(3);

        // Synchronous restart mid-GAP.
        ticks(3);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        ticks(3);

        // Randomized play.
        do_restart();
        for (int n = 0; n < 300; n++) begin
            inmap = ($urandom_range(0, 9) < 8) ? MAP : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                place_in_box();
            end else begin
                man_x = 10'($urandom_range(300, 440));
                man_y = 10'($urandom_range(140, 320));
            end
            if ($urandom_range(0, 99) < 3) begin
                hit = 1'b1;
                cyc(1);
                hit = 1'b0;
            end
            if ($urandom_range(0, 99) < 2) begin
                restart = 1'b1;
                cyc(1);
                restart = 1'b0;
            end
            frame_tick();
        end

        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
